// File: rtl/sd_stream_ctrl.sv
// Word-to-bit serializer feeding a programmable Mealy pattern detector.
// It counts the pattern hits in each word and returns the count over a valid/ready port.
//
// state | meaning
// IDLE  | ready for a word; cfg_we is honoured here
// SHIFT | one stream bit per cycle, MSB first, for WORD_W cycles
// DONE  | result held on out_valid/out_count until out_ready
module sd_stream_ctrl #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              match,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_count,
  input  logic              out_ready,
  output logic              busy
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam int BC_W   = $clog2(WORD_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q;
  logic [WORD_W-1:0]   shreg_q;
  logic [BC_W-1:0]     bit_cnt_q;
  logic [PAT_W-2:0]    hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PAT_W-1:0]    pattern_q;
  logic                overlap_q;
  logic                in_ready_q, bit_valid_q, out_valid_q, busy_q;
  logic [PAT_W-1:0]    window;

  assign bit_out   = shreg_q[WORD_W-1];
  assign window    = {hist_q, bit_out};
  assign match     = bit_valid_q && (fill_q == FILL_MAX) && (window == pattern_q);
  assign in_ready  = in_ready_q;
  assign bit_valid = bit_valid_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_count = cnt_q;

  // Detector state advances only on stream bits; it persists across word boundaries.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (bit_valid_q) begin
      hist_d = window[PAT_W-2:0];
      if (match && !overlap_q)
        fill_d = '0;
      else if (fill_q != FILL_MAX)
        fill_d = fill_q + FILL_W'(1);
      if (match && (cnt_q != CNT_MAX))
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      hist_q      <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      pattern_q   <= '0;
      overlap_q   <= 1'b1;
      in_ready_q  <= 1'b1;
      bit_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (cfg_we) begin
            pattern_q <= cfg_pattern;
            overlap_q <= cfg_overlap;
            hist_q    <= '0;
            fill_q    <= '0;
          end
          if (in_valid) begin
            shreg_q     <= in_data;
            bit_cnt_q   <= BC_LAST;
            cnt_q       <= '0;
            state_q     <= ST_SHIFT;
            in_ready_q  <= 1'b0;
            bit_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
          if (bit_cnt_q == '0) begin
            state_q     <= ST_DONE;
            bit_valid_q <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q - BC_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          bit_valid_q <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
